// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt priority controller: FSM encoding,
// default geometry and handler vector layout.
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    ACK  = 2'd2
  } irq_state_t;

  localparam int          NUM_IRQ_DEF    = 4;
  localparam logic [31:0] VEC_BASE_DEF   = 32'h0000_0800;
  localparam logic [31:0] VEC_STRIDE_DEF = 32'h0000_0010;
  localparam int          ID_W           = 3;

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational fixed-priority encoder; index 0 wins. Lines at or above the
// highest-priority in-service line are blocked so only true nesting is allowed.
module irq_prio_enc
  import irq_pkg::*;
#(
  parameter int NUM_IRQ = NUM_IRQ_DEF
) (
  input  logic [NUM_IRQ-1:0] req,
  input  logic [NUM_IRQ-1:0] mask,
  input  logic               global_en,
  input  logic [NUM_IRQ-1:0] in_service,
  output logic               valid,
  output logic [ID_W-1:0]    index
);

  logic blocked;

  // Once the scan meets an in-service bit, that line and all lower-priority ones are blocked.
  always_comb begin
    blocked = 1'b0;
    valid   = 1'b0;
    index   = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (in_service[i]) blocked = 1'b1;
      if (!valid && !blocked && req[i] && mask[i] && global_en) begin
        valid = 1'b1;
        index = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_priority_ctrl.sv
// Interrupt priority controller: masks and arbitrates sampler requests, presents
// one pending interrupt with its handler vector, and tracks nested service.
module irq_priority_ctrl
  import irq_pkg::*;
#(
  parameter int          NUM_IRQ    = NUM_IRQ_DEF,
  parameter logic [31:0] VEC_BASE   = VEC_BASE_DEF,
  parameter logic [31:0] VEC_STRIDE = VEC_STRIDE_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_req,
  output logic [NUM_IRQ-1:0] irq_clear,
  input  logic               global_en,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  output logic [NUM_IRQ-1:0] mask,
  output logic               int_pending,
  output logic [ID_W-1:0]    int_id,
  output logic [31:0]        int_vector,
  input  logic               int_ack,
  input  logic               eret,
  output logic [NUM_IRQ-1:0] in_service
);

  irq_state_t         state, state_nxt;
  logic [NUM_IRQ-1:0] mask_nxt, in_service_nxt, irq_clear_nxt;
  logic               int_pending_nxt;
  logic [ID_W-1:0]    int_id_nxt;
  logic [31:0]        int_vector_nxt;
  logic               win_valid;
  logic [ID_W-1:0]    win_id;

  irq_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_enc (
    .req        (irq_req),
    .mask       (mask),
    .global_en  (global_en),
    .in_service (in_service),
    .valid      (win_valid),
    .index      (win_id)
  );

  function automatic logic [NUM_IRQ-1:0] onehot(input logic [ID_W-1:0] id);
    logic [NUM_IRQ-1:0] v;
    for (int i = 0; i < NUM_IRQ; i++) v[i] = (id == ID_W'(i));
    return v;
  endfunction

  function automatic logic [31:0] vec_of(input logic [ID_W-1:0] id);
    return VEC_BASE + 32'(id) * VEC_STRIDE;
  endfunction

  // x & (x-1) drops the lowest set bit, i.e. the innermost (highest-priority) handler.
  always_comb begin
    state_nxt       = state;
    int_pending_nxt = int_pending;
    int_id_nxt      = int_id;
    int_vector_nxt  = int_vector;
    irq_clear_nxt   = '0;
    mask_nxt        = mask_we ? mask_wdata : mask;
    in_service_nxt  = eret ? (in_service & (in_service - NUM_IRQ'(1))) : in_service;
    case (state)
      IDLE: begin
        if (win_valid) begin
          state_nxt       = PEND;
          int_pending_nxt = 1'b1;
          int_id_nxt      = win_id;
          int_vector_nxt  = vec_of(win_id);
        end
      end
      PEND: begin
        if (int_ack) begin
          state_nxt       = ACK;
          int_pending_nxt = 1'b0;
          in_service_nxt  = in_service_nxt | onehot(int_id);
          irq_clear_nxt   = onehot(int_id);
        end else if (!win_valid) begin
          state_nxt       = IDLE;
          int_pending_nxt = 1'b0;
        end else begin
          int_id_nxt      = win_id;
          int_vector_nxt  = vec_of(win_id);
        end
      end
      ACK: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt       = IDLE;
        int_pending_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      mask        <= '0;
      in_service  <= '0;
      irq_clear   <= '0;
      int_pending <= 1'b0;
      int_id      <= '0;
      int_vector  <= VEC_BASE;
    end else begin
      state       <= state_nxt;
      mask        <= mask_nxt;
      in_service  <= in_service_nxt;
      irq_clear   <= irq_clear_nxt;
      int_pending <= int_pending_nxt;
      int_id      <= int_id_nxt;
      int_vector  <= int_vector_nxt;
    end
  end

endmodule

// File: tb/tb_irq_priority_ctrl.sv
// Directed bench for irq_priority_ctrl: a vector table for the basic and nesting
// flows, then hand-written sequences for masking, preemption, reset and global_en.
module tb_irq_priority_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  irq_req;
  logic [3:0]  irq_clear;
  logic        global_en;
  logic        mask_we;
  logic [3:0]  mask_wdata;
  logic [3:0]  mask;
  logic        int_pending;
  logic [2:0]  int_id;
  logic [31:0] int_vector;
  logic        int_ack;
  logic        eret;
  logic [3:0]  in_service;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic [3:0]  set_req;
    logic        mask_we;
    logic [3:0]  mask_wdata;
    logic        ack;
    logic        eret;
    logic        exp_pend;
    logic [2:0]  exp_id;
    logic [31:0] exp_vec;
    logic [3:0]  exp_clr;
    logic [3:0]  exp_isv;
    logic [3:0]  exp_mask;
  } vec_t;

  vec_t tbl [22];

  irq_priority_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .irq_req     (irq_req),
    .irq_clear   (irq_clear),
    .global_en   (global_en),
    .mask_we     (mask_we),
    .mask_wdata  (mask_wdata),
    .mask        (mask),
    .int_pending (int_pending),
    .int_id      (int_id),
    .int_vector  (int_vector),
    .int_ack     (int_ack),
    .eret        (eret),
    .in_service  (in_service)
  );

  always #5 clk = ~clk;

  // One clock; the sampler model drops whatever line was being cleared during the cycle.
  task automatic tick();
    logic [3:0] clr;
    clr = irq_clear;
    @(posedge clk);
    #1;
    irq_req = irq_req & ~clr;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    irq_req    = irq_req | v.set_req;
    mask_we    = v.mask_we;
    mask_wdata = v.mask_wdata;
    int_ack    = v.ack;
    eret       = v.eret;
    tick();
    mask_we = 1'b0;
    int_ack = 1'b0;
    eret    = 1'b0;
  endtask

  task automatic checkAll(input string tag, input logic pend, input logic [2:0] id,
                          input logic [31:0] vec, input logic [3:0] clr,
                          input logic [3:0] isv, input logic [3:0] msk);
    checkOutput({tag, " pend"}, 32'(int_pending), 32'(pend));
    checkOutput({tag, " id"},   32'(int_id),      32'(id));
    checkOutput({tag, " vec"},  int_vector,       vec);
    checkOutput({tag, " clr"},  32'(irq_clear),   32'(clr));
    checkOutput({tag, " isv"},  32'(in_service),  32'(isv));
    checkOutput({tag, " mask"}, 32'(mask),        32'(msk));
  endtask

  initial begin
    // set, we, wdata, ack, eret | pend, id, vec, clr, isv, mask
    tbl[0]  = '{4'h0, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 3'd0, 32'h800, 4'h0, 4'h0, 4'hF};
    tbl[1]  = '{4'h4, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 3'd2, 32'h820, 4'h0, 4'h0, 4'hF};
    tbl[2]  = '{4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 3'd2, 32'h820, 4'h0, 4'h0, 4'hF};
    tbl[3]  = '{4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 3'd2, 32'h820, 4'h4, 4'h4, 4'hF};
    tbl[4]  = '{4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 3'd2, 32'h820, 4'h0, 4'h4, 4'hF};
    tbl[5]  = '{4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 3'd2, 32'h820, 4'h0, 4'h0, 4'hF};
    tbl[6]  = '{4'hA, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 3'd1, 32'h810, 4'h0, 4'h0, 4'hF};
    tbl[7]  = '{4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 3'd1, 32'h810, 4'h2, 4'h2, 4'hF};
    tbl[8]  = '{4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 3'd1, 32'h810, 4'h0, 4'h2, 4'hF};
    tbl[9]  = '{4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 3'd1, 32'h810, 4'h0, 4'h2, 4'hF};
    tbl[10] = '{4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 3'd1, 32'h810, 4'h0, 4'h0, 4'hF};
    tbl[11] = '{4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 3'd3, 32'h830, 4'h0, 4'h0, 4'hF};
    tbl[12] = '{4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 3'd3, 32'h830, 4'h8, 4'h8, 4'hF};
    tbl[13] = '{4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 3'd3, 32'h830, 4'h0, 4'h0, 4'hF};
    tbl[14] = '{4'h4, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 3'd2, 32'h820, 4'h0, 4'h0, 4'hF};
    tbl[15] = '{4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 3'd2, 32'h820, 4'h4, 4'h4, 4'hF};
    tbl[16] = '{4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 3'd2, 32'h820, 4'h0, 4'h4, 4'hF};
    tbl[17] = '{4'h1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 3'd0, 32'h800, 4'h0, 4'h4, 4'hF};
    tbl[18] = '{4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 3'd0, 32'h800, 4'h1, 4'h5, 4'hF};
    tbl[19] = '{4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h800, 4'h0, 4'h5, 4'hF};
    tbl[20] = '{4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 3'd0, 32'h800, 4'h0, 4'h4, 4'hF};
    tbl[21] = '{4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 3'd0, 32'h800, 4'h0, 4'h0, 4'hF};

    rst = 1'b1; irq_req = 4'h0; global_en = 1'b1; mask_we = 1'b0;
    mask_wdata = 4'h0; int_ack = 1'b0; eret = 1'b0;
    tick(); tick();
    checkAll("reset", 1'b0, 3'd0, 32'h800, 4'h0, 4'h0, 4'h0);
    rst = 1'b0;

    for (int i = 0; i < 22; i++) begin
      applyStimulus(tbl[i]);
      checkAll($sformatf("row%0d", i), tbl[i].exp_pend, tbl[i].exp_id, tbl[i].exp_vec,
               tbl[i].exp_clr, tbl[i].exp_isv, tbl[i].exp_mask);
    end

    // Masking a pending line withdraws it without any clear.
    irq_req = irq_req | 4'h8; tick();
    checkAll("mask_a", 1'b1, 3'd3, 32'h830, 4'h0, 4'h0, 4'hF);
    mask_we = 1'b1; mask_wdata = 4'h7; tick(); mask_we = 1'b0;
    checkAll("mask_b", 1'b1, 3'd3, 32'h830, 4'h0, 4'h0, 4'h7);
    tick();
    checkAll("mask_c", 1'b0, 3'd3, 32'h830, 4'h0, 4'h0, 4'h7);
    tick();
    checkAll("mask_d", 1'b0, 3'd3, 32'h830, 4'h0, 4'h0, 4'h7);

    // Higher-priority arrival preempts a pending line before ack.
    irq_req = irq_req | 4'h2; tick();
    checkAll("pre_a", 1'b1, 3'd1, 32'h810, 4'h0, 4'h0, 4'h7);
    irq_req = irq_req | 4'h1; tick();
    checkAll("pre_b", 1'b1, 3'd0, 32'h800, 4'h0, 4'h0, 4'h7);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    checkAll("pre_c", 1'b0, 3'd0, 32'h800, 4'h1, 4'h1, 4'h7);
    tick();
    checkOutput("pre_req_kept", 32'(irq_req), 32'hA);
    checkAll("pre_d", 1'b0, 3'd0, 32'h800, 4'h0, 4'h1, 4'h7);
    eret = 1'b1; tick(); eret = 1'b0;
    checkAll("pre_e", 1'b0, 3'd0, 32'h800, 4'h0, 4'h0, 4'h7);
    tick();
    checkAll("pre_f", 1'b1, 3'd1, 32'h810, 4'h0, 4'h0, 4'h7);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    checkAll("pre_g", 1'b0, 3'd1, 32'h810, 4'h2, 4'h2, 4'h7);

    // Reset in ACK aborts everything; the masked-off latched line returns after unmasking.
    rst = 1'b1; tick(); rst = 1'b0;
    checkAll("rst_a", 1'b0, 3'd0, 32'h800, 4'h0, 4'h0, 4'h0);
    tick();
    checkAll("rst_b", 1'b0, 3'd0, 32'h800, 4'h0, 4'h0, 4'h0);
    mask_we = 1'b1; mask_wdata = 4'hF; tick(); mask_we = 1'b0;
    checkAll("rst_c", 1'b0, 3'd0, 32'h800, 4'h0, 4'h0, 4'hF);
    tick();
    checkAll("rst_d", 1'b1, 3'd3, 32'h830, 4'h0, 4'h0, 4'hF);

    // global_en withdraws pending; ack while idle is ignored.
    global_en = 1'b0; tick();
    checkAll("gen_a", 1'b0, 3'd3, 32'h830, 4'h0, 4'h0, 4'hF);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    checkAll("gen_b", 1'b0, 3'd3, 32'h830, 4'h0, 4'h0, 4'hF);
    global_en = 1'b1; tick();
    checkAll("gen_c", 1'b1, 3'd3, 32'h830, 4'h0, 4'h0, 4'hF);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/irq_priority_ctrl.md
Name: irq_priority_ctrl

Overview:
- Interrupt priority controller that sits directly downstream of the per-line interrupt samplers. It consumes their latched request outputs and drives each sampler's one-cycle clear input.
- Applies a software-writable enable mask and a global enable. Resolves fixed priority (index 0 highest) and supports nesting via an in-service register.
- Presents a single pending request plus a handler vector to the CPU. Handles ack and ERET handshakes.

Parameters:
- NUM_IRQ, 4, number of interrupt lines (1..8).
- VEC_BASE, 32'h0000_0800, handler address of line 0.
- VEC_STRIDE, 32'h0000_0010, address distance between consecutive handlers.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- irq_req  in  NUM_IRQ  latched requests from the samplers (their int_out).
- irq_clear  out  NUM_IRQ  one-cycle clear pulses to the samplers.
- global_en  in  1  CP0 interrupt enable; 0 blocks new pending.
- mask_we  in  1  write strobe for the mask.
- mask_wdata  in  NUM_IRQ  new mask; 1 = line enabled.
- mask  out  NUM_IRQ  current mask.
- int_pending  out  1  request to CPU; level, held until ack or withdrawal.
- int_id  out  3  index of the pending line.
- int_vector  out  32  VEC_BASE + int_id*VEC_STRIDE.
- int_ack  in  1  CPU accepts the pending interrupt this cycle; valid only while int_pending=1.
- eret  in  1  one-cycle pulse on handler return.
- in_service  out  NUM_IRQ  lines currently being serviced.

Behaviour:
- Reset: state IDLE; mask=0; in_service=0; irq_clear=0; int_pending=0; int_id=0; int_vector=VEC_BASE.
- Reset asserted mid-operation aborts everything in one cycle. Samplers keep their latched requests, which re-arbitrate once unmasked.
- Eligible line i: irq_req[i] & mask[i] & global_en & (i < index of highest-priority in_service bit). If in_service=0, all lines qualify. A line in service is never eligible, so it cannot re-trigger.
- Winner: lowest eligible index. Computed combinationally; every output is registered.
- FSM states: IDLE, PEND, ACK.
- IDLE: if any line is eligible, go to PEND, register int_id/int_vector from the winner, and set int_pending=1. Latency from irq_req rise to int_pending = 1 cycle.
- PEND:
  - Re-arbitrate every cycle. int_id/int_vector update to the new winner with 1-cycle latency, e.g. a higher-priority arrival preempts the current pending line.
  - If no line is eligible (masked, global_en low): int_pending=0, go to IDLE, no clear issued.
  - On int_ack: set in_service[int_id], go to ACK, int_pending=0.
- ACK: irq_clear[captured id]=1 for exactly this cycle; all other clear bits are 0. Next state is IDLE. The sampler drops the request at the end of ACK. Nothing new is raised from ACK.
- eret, any state: clears the lowest-index set bit of in_service. No effect if in_service=0.
- eret and int_ack in the same cycle: both applied. Eligibility that cycle uses the pre-update in_service.
- mask_we: mask updates at the next edge. The new value affects eligibility from the following cycle.
- int_ack outside PEND is ignored.
- irq_clear is never asserted outside ACK.

Decomposition:
- Package irq_pkg:
  - state encoding (IDLE=2'd0, PEND=2'd1, ACK=2'd2);
  - NUM_IRQ default, VEC_BASE, VEC_STRIDE;
  - id width constant (3).
- Sub-module irq_prio_enc: combinational priority encoder. Inputs: request vector, mask, global_en, in_service. Outputs: valid and index.
- FSM, mask register, in-service register and vector arithmetic live in the top.

Test Plan:
- Write mask=4'b1111, pulse sampler line 2 → int_pending=1 next cycle, int_id=2, int_vector=0x820. Ack → irq_clear=4'b0100 for one cycle, in_service=4'b0100.
- Lines 1 and 3 raised in the same cycle → int_id=1, vector 0x810. After ack+ACK, line 3 is not raised while in_service[1]=1. After eret → line 3 pending, vector 0x830.
- Nesting: line 2 in service, line 0 raised → pending id 0. Ack → in_service=4'b0101. First eret → 4'b0100, second eret → 4'b0000.
- Line 3 pending in PEND, write mask=4'b0111 → int_pending drops 1 cycle after the write takes effect, state IDLE, irq_clear stays 0.
- Line 1 pending, line 0 raised before ack → int_id switches 1→0 and int_vector 0x810→0x800. Ack → clear pulses bit 0 only, and line 1 remains requested.
- Assert rst during ACK → next cycle irq_clear=0, in_service=0, mask=0, int_pending=0. After mask rewrite, the still-latched line re-raises int_pending.
